// File: rtl/gmii_frame_tx_mux.sv
// rtl/gmii_frame_tx_mux.sv - round-robin FIFO-to-GMII frame transmitter with preamble, header, pad and FCS
module gmii_frame_tx_mux #(
    parameter int          DATA_W  = 48,
    parameter int          NCH     = 2,
    parameter int          WORDS   = 40,
    parameter logic [47:0] DST_MAC = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC = 48'h001122334455,
    parameter logic [15:0] ETYPE   = 16'h88B5
) (
    input  logic                    tx_clk,
    input  logic                    sys_rst_n,
    input  logic [NCH-1:0]          ch_req,
    output logic [NCH-1:0]          ch_rd_en,
    input  logic [NCH*DATA_W-1:0]   ch_dout,
    output logic                    tx_en,
    output logic [7:0]              txd,
    output logic                    busy
);

    localparam int BPW   = DATA_W / 8;
    localparam int PB    = WORDS * BPW;
    localparam int PAD_N = (16 + PB < 60) ? (60 - 16 - PB) : 0;
    localparam int GW    = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, PAD, FCS, IFG} state_t;

    state_t            state, nxt_state;
    logic [15:0]       cnt, nxt_cnt;
    logic [3:0]        bcnt, nxt_bcnt;
    logic [GW-1:0]     grant, rr, arb_idx;
    logic              arb_hit;
    logic [7:0]        seq [NCH];
    logic [31:0]       crc;
    logic [DATA_W-1:0] sh, cur_word;
    logic [7:0]        rd_left;
    logic [3:0]        rd_gap;
    logic [7:0]        nxt_byte;
    logic              nxt_en;
    logic [127:0]      hdr_vec;
    logic [31:0]       fcs_word;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign cur_word = ch_dout[int'(grant)*DATA_W +: DATA_W];
    assign hdr_vec  = {DST_MAC, SRC_MAC, ETYPE, 8'(grant), seq[grant]};
    assign fcs_word = ~crc;

    // Search starts one past the last-served channel.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!arb_hit && ch_req[(int'(rr) + i) % NCH]) begin
                arb_hit = 1'b1;
                arb_idx = GW'((int'(rr) + i) % NCH);
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 16'd1;
        nxt_bcnt  = bcnt;
        case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (arb_hit) nxt_state = PRE;
            end
            PRE: if (cnt == 16'd7) begin nxt_state = HDR; nxt_cnt = '0; end
            HDR: if (cnt == 16'd15) begin nxt_state = PAY; nxt_cnt = '0; nxt_bcnt = '0; end
            PAY: begin
                nxt_bcnt = (bcnt == 4'(BPW - 1)) ? 4'd0 : bcnt + 4'd1;
                if (cnt == 16'(PB - 1)) begin
                    nxt_state = (PAD_N > 0) ? PAD : FCS;
                    nxt_cnt   = '0;
                end
            end
            PAD: if (cnt == 16'(PAD_N - 1)) begin nxt_state = FCS; nxt_cnt = '0; end
            FCS: if (cnt == 16'd3) begin nxt_state = IFG; nxt_cnt = '0; end
            IFG: if (cnt == 16'd11) begin nxt_state = IDLE; nxt_cnt = '0; end
            default: nxt_state = IDLE;
        endcase
    end

    // Byte chosen here is the one registered onto txd at the coming edge.
    always_comb begin
        nxt_byte = 8'h00;
        case (nxt_state)
            PRE:     nxt_byte = (nxt_cnt == 16'd7) ? 8'hD5 : 8'h55;
            HDR:     nxt_byte = hdr_vec[8*(15 - int'(nxt_cnt[3:0])) +: 8];
            PAY:     nxt_byte = (nxt_bcnt == 4'd0) ? cur_word[DATA_W-1 -: 8] : sh[DATA_W-1 -: 8];
            FCS:     nxt_byte = fcs_word[8*int'(nxt_cnt[1:0]) +: 8];
            default: nxt_byte = 8'h00;
        endcase
        nxt_en = (nxt_state != IDLE) && (nxt_state != IFG);
    end

    always_ff @(posedge tx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bcnt     <= '0;
            grant    <= '0;
            rr       <= GW'(NCH - 1);
            crc      <= 32'hFFFFFFFF;
            sh       <= '0;
            rd_left  <= '0;
            rd_gap   <= '0;
            ch_rd_en <= '0;
            tx_en    <= 1'b0;
            txd      <= 8'h00;
            busy     <= 1'b0;
            for (int i = 0; i < NCH; i++) seq[i] <= 8'h00;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            bcnt  <= nxt_bcnt;
            tx_en <= nxt_en;
            txd   <= nxt_en ? nxt_byte : 8'h00;
            busy  <= (nxt_state != IDLE);

            if (state == IDLE && arb_hit) begin
                grant <= arb_idx;
                rr    <= arb_idx;
                crc   <= 32'hFFFFFFFF;
            end else if (nxt_state == HDR || nxt_state == PAY || nxt_state == PAD) begin
                crc <= crc_byte(crc, nxt_byte);
            end

            if (nxt_state == PAY)
                sh <= (nxt_bcnt == 4'd0) ? (cur_word << 8) : (sh << 8);

            if (state == FCS && cnt == 16'd3)
                seq[grant] <= seq[grant] + 8'd1;

            // First read lands two bytes ahead of payload; the rest follow every BPW bytes.
            ch_rd_en <= '0;
            if (nxt_state == HDR && nxt_cnt == 16'd14) begin
                ch_rd_en <= NCH'(1) << grant;
                rd_left  <= 8'(WORDS - 1);
                rd_gap   <= 4'(BPW - 1);
            end else if (rd_gap != 4'd0) begin
                rd_gap <= rd_gap - 4'd1;
            end else if (rd_left != 8'd0) begin
                ch_rd_en <= NCH'(1) << grant;
                rd_left  <= rd_left - 8'd1;
                rd_gap   <= 4'(BPW - 1);
            end
        end
    end

endmodule

// File: tb/tb_gmii_frame_tx_mux.sv
// tb/tb_gmii_frame_tx_mux.sv - scoreboard bench for gmii_frame_tx_mux (default build plus a padded single-channel build)
module tb_gmii_frame_tx_mux;

    localparam int PB1 = 240;
    localparam int PB2 = 12;

    logic        tx_clk = 1'b0;
    logic        sys_rst_n, rst2_n;
    logic [1:0]  ch_req, ch_rd_en;
    logic [47:0] d0, d1, d2, w0, w1, w2;
    logic [95:0] ch_dout;
    logic        tx_en, busy, tx_en2, busy2;
    logic [7:0]  txd, txd2;
    logic [0:0]  req2, rd2;

    int checks = 0, errors = 0;
    int starts1 = 0, done1 = 0, starts2 = 0, done2 = 0;
    int rdc0 = 0, rdc1 = 0, rdc2 = 0, ifg1 = 0;
    int idle_bad1 = 0, idle_bad2 = 0, busy_bad = 0;
    bit in1 = 0, in2 = 0, have_prev1 = 0;
    logic [7:0]  fr1[$], fr2[$], exp0[$], exp1[$], exp2[$];
    logic [15:0] exp_hdr[$];
    logic [7:0]  seq_m [2];

    assign ch_dout = {d1, d0};

    always #4 tx_clk = ~tx_clk;

    gmii_frame_tx_mux dut (
        .tx_clk(tx_clk), .sys_rst_n(sys_rst_n), .ch_req(ch_req), .ch_rd_en(ch_rd_en),
        .ch_dout(ch_dout), .tx_en(tx_en), .txd(txd), .busy(busy)
    );

    gmii_frame_tx_mux #(.DATA_W(48), .NCH(1), .WORDS(2)) dut2 (
        .tx_clk(tx_clk), .sys_rst_n(rst2_n), .ch_req(req2), .ch_rd_en(rd2),
        .ch_dout(d2), .tx_en(tx_en2), .txd(txd2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] f[$], input int pb, input int padn,
                               input logic [7:0] ech, input logic [7:0] eseq, input logic [7:0] pay[$]);
        int n, bad;
        logic [127:0] h;
        logic [31:0] c;
        n = 8 + 16 + pb + padn + 4;
        chk({tag, "_len"}, 64'(f.size()), 64'(n));
        if (f.size() != n) return;
        bad = 0;
        for (int i = 0; i < 7; i++) if (f[i] != 8'h55) bad++;
        if (f[7] != 8'hD5) bad++;
        chk({tag, "_preamble"}, 64'(bad), 0);
        h = '0;
        for (int i = 0; i < 16; i++) h = {h[119:0], f[8+i]};
        chk({tag, "_dst"},   64'(h[127:80]), 64'h0000FFFFFFFFFFFF);
        chk({tag, "_src"},   64'(h[79:32]),  64'h0000001122334455);
        chk({tag, "_etype"}, 64'(h[31:16]),  64'h88B5);
        chk({tag, "_chan"},  64'(h[15:8]),   64'(ech));
        chk({tag, "_seq"},   64'(h[7:0]),    64'(eseq));
        bad = 0;
        for (int i = 0; i < pb; i++) if (i >= pay.size() || f[24+i] !== pay[i]) bad++;
        chk({tag, "_payload"}, 64'(bad), 0);
        bad = 0;
        for (int i = 0; i < padn; i++) if (f[24+pb+i] != 8'h00) bad++;
        chk({tag, "_pad"}, 64'(bad), 0);
        c = 32'hFFFFFFFF;
        for (int i = 8; i < n; i++) c = crc_upd(c, f[i]);
        chk({tag, "_crc_residue"}, 64'(c), 64'hDEBB20E3);
    endtask

    // FIFO models: data valid only in the cycle after the read strobe, garbage otherwise.
    always @(posedge tx_clk) begin
        w0 = 48'({$urandom, $urandom});
        w1 = 48'({$urandom, $urandom});
        w2 = 48'({$urandom, $urandom});
        if (ch_rd_en[0]) for (int k = 0; k < 6; k++) exp0.push_back(w0[47-8*k -: 8]);
        if (ch_rd_en[1]) for (int k = 0; k < 6; k++) exp1.push_back(w1[47-8*k -: 8]);
        if (rd2[0])      for (int k = 0; k < 6; k++) exp2.push_back(w2[47-8*k -: 8]);
        d0 <= w0;
        d1 <= w1;
        d2 <= w2;
    end

    task automatic end_frame1();
        logic [15:0] h;
        logic [7:0]  pay[$];
        int short_n;
        short_n = 0;
        h = 16'hFFFF;
        chk("hdr_queue_empty", 64'(exp_hdr.size() == 0), 0);
        if (exp_hdr.size() != 0) h = exp_hdr.pop_front();
        for (int i = 0; i < PB1; i++) begin
            if (h[15:8] == 8'd0 && exp0.size() != 0)      pay.push_back(exp0.pop_front());
            else if (h[15:8] == 8'd1 && exp1.size() != 0) pay.push_back(exp1.pop_front());
            else short_n++;
        end
        chk("pay_queue_short", 64'(short_n), 0);
        check_frame("f1", fr1, PB1, 0, h[15:8], h[7:0], pay);
        chk("rd_cnt_grant", 64'((h[15:8] == 8'd0) ? rdc0 : rdc1), 40);
        chk("rd_cnt_other", 64'((h[15:8] == 8'd0) ? rdc1 : rdc0), 0);
        fr1.delete();
        rdc0 = 0;
        rdc1 = 0;
        done1++;
    endtask

    task automatic end_frame2();
        logic [7:0] pay[$];
        int short_n;
        short_n = 0;
        for (int i = 0; i < PB2; i++) begin
            if (exp2.size() != 0) pay.push_back(exp2.pop_front());
            else short_n++;
        end
        chk("pay2_queue_short", 64'(short_n), 0);
        check_frame("f2", fr2, PB2, 32, 8'h00, 8'(done2), pay);
        chk("rd2_cnt", 64'(rdc2), 2);
        fr2.delete();
        rdc2 = 0;
        done2++;
    endtask

    always @(negedge tx_clk) begin
        if (!sys_rst_n) begin
            fr1.delete(); exp0.delete(); exp1.delete();
            rdc0 = 0; rdc1 = 0; in1 = 0; have_prev1 = 0;
        end else begin
            if (ch_rd_en[0]) rdc0++;
            if (ch_rd_en[1]) rdc1++;
            if (tx_en) begin
                if (!busy) busy_bad++;
                if (!in1) begin
                    starts1++;
                    if (have_prev1) chk("ifg_len", 64'(ifg1), 12);
                    in1 = 1;
                end
                fr1.push_back(txd);
            end else begin
                if (txd != 8'h00) idle_bad1++;
                if (in1) begin
                    in1 = 0;
                    end_frame1();
                    ifg1 = 0;
                    have_prev1 = 1;
                end
                if (busy) ifg1++;
            end
        end
    end

    always @(negedge tx_clk) begin
        if (!rst2_n) begin
            fr2.delete(); exp2.delete();
            rdc2 = 0; in2 = 0;
        end else begin
            if (rd2[0]) rdc2++;
            if (tx_en2) begin
                if (!in2) begin starts2++; in2 = 1; end
                fr2.push_back(txd2);
            end else begin
                if (txd2 != 8'h00) idle_bad2++;
                if (in2) begin in2 = 0; end_frame2(); end
            end
        end
    end

    task automatic exp_push(input int ch);
        exp_hdr.push_back({8'(ch), seq_m[ch]});
        seq_m[ch] = seq_m[ch] + 8'd1;
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 3000 && starts1 < n; i++) @(negedge tx_clk);
        chk("wait_start", 64'(starts1 >= n), 1);
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 3000 && done1 < n; i++) @(negedge tx_clk);
        chk("wait_done", 64'(done1 >= n), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_en"}, 64'(tx_en), 0);
        chk({tag, "_txd"},   64'(txd), 0);
        chk({tag, "_rd_en"}, 64'(ch_rd_en), 0);
        chk({tag, "_busy"},  64'(busy), 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rst2_n    = 1'b0;
        ch_req    = 2'b00;
        req2      = 1'b0;
        seq_m[0]  = 8'h00;
        seq_m[1]  = 8'h00;
        repeat (3) @(negedge tx_clk);
        check_reset_outputs("rst");
        chk("rst2_tx_en", 64'(tx_en2), 0);
        @(negedge tx_clk);
        sys_rst_n = 1'b1;
        rst2_n    = 1'b1;
        req2      = 1'b1;

        ch_req = 2'b01; exp_push(0);
        wait_starts(1); ch_req = 2'b00; wait_done(1);

        ch_req = 2'b11; exp_push(1); exp_push(0); exp_push(1);
        wait_starts(4); ch_req = 2'b00; wait_done(4);

        ch_req = 2'b10; exp_push(1);
        wait_starts(5); ch_req = 2'b00; wait_done(5);

        ch_req = 2'b01; exp_push(0);
        wait_starts(6);
        repeat (60) @(negedge tx_clk);
        #1 sys_rst_n = 1'b0;
        #1 check_reset_outputs("midframe_rst");
        ch_req = 2'b11;
        seq_m[0] = 8'h00;
        seq_m[1] = 8'h00;
        exp_hdr.delete();
        repeat (3) @(negedge tx_clk);
        sys_rst_n = 1'b1;
        exp_push(0);
        wait_starts(7); ch_req = 2'b00; wait_done(6);

        for (int i = 0; i < 30000 && done2 < 257; i++) @(negedge tx_clk);
        req2 = 1'b0;
        chk("wait_dut2_frames", 64'(done2 >= 257), 1);
        repeat (40) @(negedge tx_clk);
        chk("dut2_frame_count", 64'(starts2), 257);
        chk("idle_txd_nonzero", 64'(idle_bad1 + idle_bad2), 0);
        chk("busy_low_in_frame", 64'(busy_bad), 0);
        chk("dut_idle_at_end", 64'(tx_en | busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
